// File: rtl/modn_counter.sv
// Modulo-N up/down counter with synchronous clear/load, a cascadable
// terminal count, and a one-shot mode that parks at the terminal value.
module modn_counter #(
  parameter int MODULUS   = 10,
  parameter int WIDTH     = 4,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  localparam int               EXT_W   = WIDTH + 1;
  localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t state;

  logic [EXT_W-1:0] count_ext;
  logic [EXT_W-1:0] load_ext;
  logic [EXT_W-1:0] step_ext;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_val;
  logic             at_term;
  logic             running;

  assign count_ext    = {1'b0, count};
  assign load_ext     = {1'b0, load_val};
  assign term_val     = up ? MAX_VAL : '0;
  assign at_term      = (count == term_val);
  assign running      = (state == RUN);
  assign tc           = en & at_term & running;
  assign load_clamped = (load_ext > MAX_EXT) ? MAX_VAL : load_val;

  // Extra bit exposes over/underflow; any escape folds back to the top value.
  assign step_ext = up ? (count_ext + EXT_W'(1)) : (count_ext - EXT_W'(1));
  assign step_val = (step_ext > MAX_EXT) ? MAX_VAL : step_ext[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      count <= RST_VAL;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else if (clr) begin
      state <= RUN;
      count <= RST_VAL;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else if (load) begin
      state <= RUN;
      count <= load_clamped;
      wrap  <= 1'b0;
      done  <= 1'b0;
    end else if (en && running) begin
      if (!at_term) begin
        count <= step_val;
        wrap  <= 1'b0;
      end else if (!oneshot) begin
        count <= up ? '0 : MAX_VAL;
        wrap  <= 1'b1;
      end else begin
        // One-shot run parks at the terminal value until clr or load.
        state <= HALT;
        done  <= 1'b1;
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_modn_counter.sv
// Bench for modn_counter: three parameterisations plus a two-digit cascade,
// checked every cycle against an arithmetic model and by directed literals.
module tb_modn_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic [2:0] load_val3;
  logic       en;
  logic       up;
  logic       oneshot;
  logic       casc_en;
  logic       started = 1'b0;

  logic [3:0] count_a, count_b, units_count, tens_count;
  logic [2:0] count_c;
  logic       tc_a, wrap_a, done_a;
  logic       tc_b, wrap_b, done_b;
  logic       tc_c, wrap_c, done_c;
  logic       units_tc, units_wrap, units_done;
  logic       tens_tc, tens_wrap, tens_done;

  int checks   = 0;
  int failures = 0;

  assign load_val3 = load_val[2:0];

  always #5 clk = ~clk;

  modn_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .oneshot(oneshot),
    .count(count_a), .tc(tc_a), .wrap(wrap_a), .done(done_a));

  modn_counter #(.MODULUS(16), .WIDTH(4), .RESET_VAL(0)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .oneshot(oneshot),
    .count(count_b), .tc(tc_b), .wrap(wrap_b), .done(done_b));

  modn_counter #(.MODULUS(5), .WIDTH(3), .RESET_VAL(2)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val3),
    .en(en), .up(up), .oneshot(oneshot),
    .count(count_c), .tc(tc_c), .wrap(wrap_c), .done(done_c));

  modn_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) units (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .en(casc_en), .up(1'b1), .oneshot(1'b0),
    .count(units_count), .tc(units_tc), .wrap(units_wrap), .done(units_done));

  modn_counter #(.MODULUS(10), .WIDTH(4), .RESET_VAL(0)) tens (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
    .en(units_tc), .up(1'b1), .oneshot(1'b0),
    .count(tens_count), .tc(tens_tc), .wrap(tens_wrap), .done(tens_done));

  // Behavioural model: one entry per single-stage instance, plus the
  // cascade tracked as a plain 0..99 integer.
  int m_mod  [3] = '{10, 16, 5};
  int m_rv   [3] = '{0, 0, 2};
  int m_mask [3] = '{15, 15, 7};
  int m_cnt  [3] = '{0, 0, 2};
  bit m_halt [3] = '{0, 0, 0};
  bit m_wrap [3] = '{0, 0, 0};
  bit m_done [3] = '{0, 0, 0};
  int casc_n = 0;
  bit u_wrap = 0;
  bit t_wrap = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] = m_rv[i]; m_halt[i] = 0; m_wrap[i] = 0; m_done[i] = 0;
      end
      casc_n = 0; u_wrap = 0; t_wrap = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        int lv;
        int term;
        lv   = int'(load_val) & m_mask[i];
        term = up ? m_mod[i] - 1 : 0;
        if (clr) begin
          m_cnt[i] = m_rv[i]; m_halt[i] = 0; m_done[i] = 0; m_wrap[i] = 0;
        end else if (load) begin
          m_cnt[i] = (lv > m_mod[i] - 1) ? m_mod[i] - 1 : lv;
          m_halt[i] = 0; m_done[i] = 0; m_wrap[i] = 0;
        end else if (en && !m_halt[i]) begin
          if (m_cnt[i] != term) begin
            m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
            m_wrap[i] = 0;
          end else if (!oneshot) begin
            m_cnt[i] = up ? 0 : m_mod[i] - 1;
            m_wrap[i] = 1;
          end else begin
            m_halt[i] = 1; m_done[i] = 1; m_wrap[i] = 0;
          end
        end else begin
          m_wrap[i] = 0;
        end
      end
      if (casc_en) begin
        u_wrap = (casc_n % 10 == 9);
        t_wrap = (casc_n == 99);
        casc_n = (casc_n + 1) % 100;
      end else begin
        u_wrap = 0; t_wrap = 0;
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      int dc [3];
      int dt [3];
      int dw [3];
      int dd [3];
      dc = '{int'(count_a), int'(count_b), int'(count_c)};
      dt = '{int'(tc_a), int'(tc_b), int'(tc_c)};
      dw = '{int'(wrap_a), int'(wrap_b), int'(wrap_c)};
      dd = '{int'(done_a), int'(done_b), int'(done_c)};
      for (int i = 0; i < 3; i++) begin
        int term;
        term = up ? m_mod[i] - 1 : 0;
        check_output($sformatf("model_count%0d", i), dc[i], m_cnt[i]);
        check_output($sformatf("model_tc%0d", i), dt[i],
                     int'(en && !m_halt[i] && m_cnt[i] == term));
        check_output($sformatf("model_wrap%0d", i), dw[i], int'(m_wrap[i]));
        check_output($sformatf("model_done%0d", i), dd[i], int'(m_done[i]));
      end
      check_output("model_units", int'(units_count), casc_n % 10);
      check_output("model_tens", int'(tens_count), casc_n / 10);
      check_output("model_units_tc", int'(units_tc), int'(casc_en && casc_n % 10 == 9));
      check_output("model_tens_tc", int'(tens_tc), int'(casc_en && casc_n == 99));
      check_output("model_units_wrap", int'(units_wrap), int'(u_wrap));
      check_output("model_tens_wrap", int'(tens_wrap), int'(t_wrap));
    end
  end

  // Inputs change 1 time unit after a rising edge and are held for n edges.
  task automatic apply_stimulus(input logic c, input logic l, input logic [3:0] v,
                                input logic e, input logic u, input logic o, input int n);
    clr = c; load = l; load_val = v; en = e; up = u; oneshot = o;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulls reset low between edges and checks outputs before any clock edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    check_output({tag, "_count_a"}, int'(count_a), 0);
    check_output({tag, "_wrap_a"}, int'(wrap_a), 0);
    check_output({tag, "_done_a"}, int'(done_a), 0);
    check_output({tag, "_count_b"}, int'(count_b), 0);
    check_output({tag, "_count_c"}, int'(count_c), 2);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; casc_en = 1'b0;
    apply_stimulus(0, 0, 0, 0, 1, 0, 2);
    check_output("rst_count_a", int'(count_a), 0);
    check_output("rst_done_a", int'(done_a), 0);
    check_output("rst_count_c", int'(count_c), 2);
    rst = 1'b1;
    started = 1'b1;

    apply_stimulus(0, 0, 0, 1, 1, 0, 9);
    check_output("up_count9", int'(count_a), 9);
    check_output("up_tc9", int'(tc_a), 1);
    apply_stimulus(0, 0, 0, 1, 1, 0, 1);
    check_output("up_wrap_count", int'(count_a), 0);
    check_output("up_wrap_pulse", int'(wrap_a), 1);
    apply_stimulus(0, 0, 0, 1, 1, 0, 1);
    check_output("up_wrap_gone", int'(wrap_a), 0);

    apply_stimulus(0, 1, 3, 0, 1, 0, 1);
    check_output("load3", int'(count_a), 3);
    apply_stimulus(0, 0, 0, 1, 0, 0, 4);
    check_output("down_count9", int'(count_a), 9);
    check_output("down_wrap", int'(wrap_a), 1);
    apply_stimulus(0, 0, 0, 1, 1, 0, 1);
    check_output("dirswitch_count", int'(count_a), 0);
    check_output("dirswitch_wrap", int'(wrap_a), 1);

    apply_stimulus(0, 1, 7, 0, 1, 0, 1);
    check_output("load7", int'(count_a), 7);
    apply_stimulus(0, 1, 14, 0, 1, 0, 1);
    check_output("clamp_a", int'(count_a), 9);
    check_output("noclamp_b", int'(count_b), 14);
    check_output("clamp_c", int'(count_c), 4);
    apply_stimulus(1, 1, 5, 0, 1, 0, 1);
    check_output("clr_over_load_a", int'(count_a), 0);
    check_output("clr_over_load_c", int'(count_c), 2);
    apply_stimulus(0, 1, 4, 0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1, 0, 5);
    check_output("hold_en0", int'(count_a), 4);

    apply_stimulus(1, 0, 0, 0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 1, 1, 1, 9);
    check_output("os_count9", int'(count_a), 9);
    check_output("os_done_early", int'(done_a), 0);
    apply_stimulus(0, 0, 0, 1, 1, 1, 1);
    check_output("os_halt_count", int'(count_a), 9);
    check_output("os_done", int'(done_a), 1);
    check_output("os_nowrap", int'(wrap_a), 0);
    check_output("os_tc_off", int'(tc_a), 0);
    apply_stimulus(0, 0, 0, 0, 1, 1, 2);
    apply_stimulus(0, 0, 0, 1, 1, 0, 2);
    check_output("os_still_halted", int'(count_a), 9);
    check_output("os_still_done", int'(done_a), 1);
    async_reset("areset_halt");

    apply_stimulus(1, 0, 0, 0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 1, 1, 0, 6);
    check_output("run_count6", int'(count_a), 6);
    async_reset("areset_run6");

    apply_stimulus(1, 0, 0, 0, 1, 0, 1);
    apply_stimulus(0, 0, 0, 1, 1, 0, 10);
    check_output("pending_wrap", int'(wrap_a), 1);
    async_reset("areset_wrap");

    apply_stimulus(0, 0, 0, 0, 1, 0, 1);
    casc_en = 1'b1;
    repeat (99) @(posedge clk);
    #1;
    check_output("casc_units99", int'(units_count), 9);
    check_output("casc_tens99", int'(tens_count), 9);
    repeat (1) @(posedge clk);
    #1;
    check_output("casc_units00", int'(units_count), 0);
    check_output("casc_tens00", int'(tens_count), 0);
    check_output("casc_units_wrap", int'(units_wrap), 1);
    check_output("casc_tens_wrap", int'(tens_wrap), 1);
    casc_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
